// File: rtl/hermes_inject_mux.sv
// hermes_inject_mux: packet-level N-to-1 merge of flit sources onto one Hermes
// local/boundary port. Each source has a small credit-based FIFO. A round-robin
// arbiter hands the output to one source for a whole packet (header, size, payload).
// Optional build macro HERMES_INJ_MUX_STATS_EN adds per-source completed-packet
// counters on pkt_count_o.
module hermes_inject_mux #(
  parameter int N_SRC      = 2,
  parameter int FLIT_SIZE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0]           src_rx_i,
  output logic [N_SRC-1:0]           src_credit_o,
  input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
  output logic                       noc_tx_o,
  input  logic                       noc_credit_i,
  output logic [FLIT_SIZE-1:0]       noc_data_o,
  output logic [N_SRC-1:0]           grant_o,
  output logic                       busy_o
`ifdef HERMES_INJ_MUX_STATS_EN
  ,
  output logic [N_SRC*32-1:0]        pkt_count_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

  state_t               state_q, state_d;
  logic [FLIT_SIZE-1:0] mem_q    [N_SRC][FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q [N_SRC];
  logic [PW-1:0]        rd_ptr_q [N_SRC];
  logic [CW-1:0]        count_q  [N_SRC];
  logic [N_SRC-1:0]     push, pop, nonempty;
  logic [OW-1:0]        owner_q, rr_ptr_q, arb_idx, arb_scan;
  logic                 arb_found;
  logic [N_SRC-1:0]     grant_q;
  logic [FLIT_SIZE-1:0] remaining_q, head;
  logic                 xfer, pkt_done;

  // Per-source credit and occupancy, all from the registered counts.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_credit_o[i] = (count_q[i] != CW'(FIFO_DEPTH));
      nonempty[i]     = (count_q[i] != '0);
      push[i]         = src_rx_i[i] && (count_q[i] != CW'(FIFO_DEPTH));
    end
  end

  // Only the current owner's FIFO is popped, and only on an output transfer.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      pop[i] = xfer && (owner_q == OW'(i));
    end
  end

  assign head       = mem_q[owner_q][rd_ptr_q[owner_q]];
  assign noc_tx_o   = (state_q != IDLE) && nonempty[owner_q];
  assign noc_data_o = (state_q != IDLE) ? head : '0;
  assign xfer       = noc_tx_o && noc_credit_i;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);

  // A packet ends on the size flit when the size is zero, else on the last payload flit.
  assign pkt_done = xfer && (((state_q == SIZE) && (head == '0)) ||
                             ((state_q == PAYLOAD) && (remaining_q == FLIT_SIZE'(1))));

  // Round-robin search: first non-empty FIFO after the last owner, circular.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    arb_scan  = rr_ptr_q;
    for (int k = 0; k < N_SRC; k++) begin
      if (arb_scan == OW'(N_SRC - 1)) arb_scan = '0;
      else                            arb_scan = arb_scan + 1'b1;
      if (!arb_found && nonempty[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = arb_scan;
      end
    end
  end

  // Packet framing FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_found) state_d = HEADER;
      HEADER:  if (xfer) state_d = SIZE;
      SIZE:    if (xfer) state_d = (head == '0) ? IDLE : PAYLOAD;
      PAYLOAD: if (pkt_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FIFO pointers and occupancy; a full FIFO never accepts, even when popping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  // FIFO storage writes.
  // NOTE: storage has no reset; the occupancy counts alone decide what is valid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= src_data_i[i*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  // Ownership, grant, payload countdown and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= '0;
      grant_q     <= '0;
      remaining_q <= '0;
      rr_ptr_q    <= OW'(N_SRC - 1);
    end else begin
      if ((state_q == IDLE) && arb_found) begin
        owner_q <= arb_idx;
        grant_q <= N_SRC'(1) << arb_idx;
      end
      if ((state_q == SIZE) && xfer)    remaining_q <= head;
      if ((state_q == PAYLOAD) && xfer) remaining_q <= remaining_q - 1'b1;
      if (pkt_done) begin
        rr_ptr_q <= owner_q;
        grant_q  <= '0;
      end
    end
  end

`ifdef HERMES_INJ_MUX_STATS_EN
  logic [N_SRC-1:0][31:0] pkt_cnt_q;

  // Completed-packet counters, wrapping modulo 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q <= '0;
    end else if (pkt_done) begin
      pkt_cnt_q[owner_q] <= pkt_cnt_q[owner_q] + 32'd1;
    end
  end

  assign pkt_count_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_hermes_inject_mux.sv
// Self-checking bench for hermes_inject_mux (N_SRC=2, FLIT_SIZE=32, FIFO_DEPTH=4).
module tb_hermes_inject_mux;

  localparam int NS = 2;
  localparam int FW = 32;

  typedef logic [31:0] pkt_t [8];

  typedef struct {
    logic        rx0;
    logic [31:0] d0;
    logic        exp_tx;
    logic [31:0] exp_data;
    logic [1:0]  exp_grant;
    logic        exp_busy;
    logic [1:0]  exp_credit;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NS-1:0]     src_rx_i;
  logic [NS-1:0]     src_credit_o;
  logic [NS*FW-1:0]  src_data_i;
  logic              noc_tx_o;
  logic              noc_credit_i;
  logic [FW-1:0]     noc_data_o;
  logic [NS-1:0]     grant_o;
  logic              busy_o;
`ifdef HERMES_INJ_MUX_STATS_EN
  logic [NS*32-1:0]  pkt_count_o;
`endif

  hermes_inject_mux #(.N_SRC(NS), .FLIT_SIZE(FW), .FIFO_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .src_rx_i     (src_rx_i),
    .src_credit_o (src_credit_o),
    .src_data_i   (src_data_i),
    .noc_tx_o     (noc_tx_o),
    .noc_credit_i (noc_credit_i),
    .noc_data_o   (noc_data_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
`ifdef HERMES_INJ_MUX_STATS_EN
    ,
    .pkt_count_o  (pkt_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_d [16];
  logic [1:0]  got_g [16];
  int          got_c [16];
  int          got_n;
  logic [31:0] exp_d [16];
  logic [1:0]  exp_g [16];
  int          exp_n;

  vec_t vt [7];
  pkt_t pa, pb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    src_rx_i     = '0;
    src_data_i   = '0;
    noc_credit_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // Source model: holds each flit until the mux shows credit at a clock edge.
  task automatic send(input int s, input pkt_t f, input int n);
    for (int i = 0; i < n; i++) begin
      int   w;
      logic acc;
      w   = 0;
      acc = 1'b0;
      src_rx_i[s]            = 1'b1;
      src_data_i[s*FW +: FW] = f[i];
      while (!acc && w < 100) begin
        @(negedge clk_i);
        acc = src_credit_o[s];
        @(posedge clk_i);
        #1;
        w++;
      end
      check("send_accept", 32'(acc), 32'd1);
    end
    src_rx_i[s] = 1'b0;
  endtask

  // Records every output transfer (valid and credit both high) with its cycle.
  task automatic collect(input int n, input int budget);
    int waited;
    waited = 0;
    got_n  = 0;
    while (got_n < n && waited < budget) begin
      @(negedge clk_i);
      waited++;
      if (noc_tx_o && noc_credit_i) begin
        got_d[got_n] = noc_data_o;
        got_g[got_n] = grant_o;
        got_c[got_n] = cyc;
        got_n++;
      end
    end
    check("collect_count", got_n, n);
  endtask

  task automatic expect_pkt(input int s, input pkt_t f, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d[exp_n] = f[i];
      exp_g[exp_n] = (s == 0) ? 2'b01 : 2'b10;
      exp_n++;
    end
  endtask

  task automatic check_stream(input string name);
    for (int i = 0; i < exp_n; i++) begin
      check({name, "_data"}, got_d[i], exp_d[i]);
      check({name, "_grant"}, 32'(got_g[i]), 32'(exp_g[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked while reset is still asserted.
    rst_i        = 1'b1;
    src_rx_i     = '0;
    src_data_i   = '0;
    noc_credit_i = 1'b1;
    #2;
    check("rst_credit", 32'(src_credit_o), 32'h3);
    check("rst_tx",     32'(noc_tx_o),     32'h0);
    check("rst_data",   noc_data_o,        32'h0);
    check("rst_grant",  32'(grant_o),      32'h0);
    check("rst_busy",   32'(busy_o),       32'h0);

    // Test 1: single packet from src0, per-cycle table.
    //           rx0   d0          tx    data        grant  busy  credit
    vt[0] = '{1'b1, 32'h102, 1'b0, 32'h0,   2'b00, 1'b0, 2'b11};
    vt[1] = '{1'b1, 32'h2,   1'b0, 32'h0,   2'b00, 1'b0, 2'b11};
    vt[2] = '{1'b1, 32'hA,   1'b1, 32'h102, 2'b01, 1'b1, 2'b11};
    vt[3] = '{1'b1, 32'hB,   1'b1, 32'h2,   2'b01, 1'b1, 2'b11};
    vt[4] = '{1'b0, 32'h0,   1'b1, 32'hA,   2'b01, 1'b1, 2'b11};
    vt[5] = '{1'b0, 32'h0,   1'b1, 32'hB,   2'b01, 1'b1, 2'b11};
    vt[6] = '{1'b0, 32'h0,   1'b0, 32'h0,   2'b00, 1'b0, 2'b11};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      src_rx_i[0]      = vt[i].rx0;
      src_data_i[31:0] = vt[i].d0;
      @(negedge clk_i);
      check($sformatf("t1_tx[%0d]", i),     32'(noc_tx_o),     32'(vt[i].exp_tx));
      check($sformatf("t1_data[%0d]", i),   noc_data_o,        vt[i].exp_data);
      check($sformatf("t1_grant[%0d]", i),  32'(grant_o),      32'(vt[i].exp_grant));
      check($sformatf("t1_busy[%0d]", i),   32'(busy_o),       32'(vt[i].exp_busy));
      check($sformatf("t1_credit[%0d]", i), 32'(src_credit_o), 32'(vt[i].exp_credit));
      @(posedge clk_i);
      #1;
    end

    // Test 2: both sources load a 1-payload packet together, two rounds.
    do_reset();
    pa = '{32'hA0, 32'h1, 32'hA1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pb = '{32'hB0, 32'h1, 32'hB1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int r = 0; r < 2; r++) begin
      exp_n = 0;
      expect_pkt(0, pa, 3);
      expect_pkt(1, pb, 3);
      fork
        send(0, pa, 3);
        send(1, pb, 3);
        collect(6, 60);
      join
      check_stream($sformatf("t2_r%0d", r));
      check($sformatf("t2_gap_r%0d", r), 32'(got_c[3] - got_c[2]), 32'd2);
      repeat (3) @(posedge clk_i);
      #1;
    end

    // Test 3: size-6 packet with credit withheld for 10 cycles after the header.
    do_reset();
    pa = '{32'h0300, 32'h6, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6};
    exp_n = 0;
    expect_pkt(0, pa, 8);
    fork
      send(0, pa, 8);
      collect(8, 80);
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk_i);
          w++;
        end while (!(noc_tx_o && noc_credit_i) && w < 50);
        @(posedge clk_i);
        #1;
        noc_credit_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk_i);
          check($sformatf("t3_hold_data[%0d]", k), noc_data_o, 32'h6);
          check($sformatf("t3_hold_tx[%0d]", k), 32'(noc_tx_o), 32'h1);
        end
        check("t3_full_credit0", 32'(src_credit_o[0]), 32'h0);
        @(posedge clk_i);
        #1;
        noc_credit_i = 1'b1;
      end
    join
    check_stream("t3");

    // Test 4: size-0 packet followed by a queued packet from the same source.
    do_reset();
    pa = '{32'h0201, 32'h0, 32'h0202, 32'h1, 32'hC, 32'h0, 32'h0, 32'h0};
    exp_n = 0;
    expect_pkt(0, pa, 5);
    fork
      send(0, pa, 5);
      collect(5, 60);
    join
    check_stream("t4");
    check("t4_gap", 32'(got_c[2] - got_c[1]), 32'd2);
    @(negedge clk_i);
    check("t4_idle_busy", 32'(busy_o), 32'h0);
    @(posedge clk_i);
    #1;

    // Test 5: reset asserted mid-payload, then a fresh packet goes out intact.
    do_reset();
    pa = '{32'h0400, 32'h3, 32'hE1, 32'hE2, 32'hE3, 32'h0, 32'h0, 32'h0};
    send(0, pa, 5);
    check("t5_pre_busy", 32'(busy_o), 32'h1);
    check("t5_pre_tx",   32'(noc_tx_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t5_rst_tx",     32'(noc_tx_o),     32'h0);
    check("t5_rst_grant",  32'(grant_o),      32'h0);
    check("t5_rst_busy",   32'(busy_o),       32'h0);
    check("t5_rst_credit", 32'(src_credit_o), 32'h3);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    pb = '{32'h0500, 32'h1, 32'hD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_n = 0;
    expect_pkt(1, pb, 3);
    fork
      send(1, pb, 3);
      collect(3, 40);
    join
    check_stream("t5_after");

`ifdef HERMES_INJ_MUX_STATS_EN
    // Test 6: completed-packet counters and 32-bit wrap.
    do_reset();
    pa = '{32'h0601, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int p = 0; p < 3; p++) send(1, pa, 2);
    send(0, pa, 2);
    repeat (12) @(posedge clk_i);
    #1;
    check("t6_cnt1", pkt_count_o[63:32], 32'd3);
    check("t6_cnt0", pkt_count_o[31:0],  32'd1);
    force dut.pkt_cnt_q[0] = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.pkt_cnt_q[0];
    check("t6_preload", pkt_count_o[31:0], 32'hFFFF_FFFF);
    send(0, pa, 2);
    repeat (8) @(posedge clk_i);
    #1;
    check("t6_wrap", pkt_count_o[31:0], 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hermes_inject_mux.md
Name: hermes_inject_mux

Overview:
Packet-level N-to-1 multiplexer that merges several external flit sources onto a single Hermes local/boundary port. Typical sources are the MA injector, the app injector and future peripherals. Each source has a small credit-based input FIFO. A round-robin arbiter grants the output port for exactly one whole Hermes packet (header, size, payload) at a time, so packets from different sources never interleave. It sits between injector/peripheral outputs and a boundary PE router port in the many-core top.

Parameters:
N_SRC, 2, number of source channels (1..8)
FLIT_SIZE, 32, flit width in bits
FIFO_DEPTH, 4, per-source FIFO depth in flits (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
src_rx_i  in  N_SRC  per-source flit valid
src_credit_o  out  N_SRC  per-source credit; high = FIFO can accept a flit
src_data_i  in  N_SRC x FLIT_SIZE  per-source flit data
noc_tx_o  out  1  output flit valid
noc_credit_i  in  1  router credit; high = router accepts flit this cycle
noc_data_o  out  FLIT_SIZE  output flit
grant_o  out  N_SRC  one-hot current packet owner; 0 when idle
busy_o  out  1  high while a packet is in flight (state != IDLE)
pkt_count_o  out  N_SRC x 32  completed-packet counters; present only with HERMES_INJ_MUX_STATS_EN

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - src_credit_o = all 1; noc_tx_o = 0; noc_data_o = 0; grant_o = 0; busy_o = 0.
  - FIFOs empty; state IDLE; round-robin pointer = N_SRC-1, so source 0 has first priority.
- Source push:
  - A flit is written when src_rx_i[i] && src_credit_o[i].
  - src_credit_o[i] = (count[i] != FIFO_DEPTH), taken from registered count.
  - A full FIFO refuses a push even if it pops in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Output handshake:
  - noc_tx_o = (state != IDLE) && owner FIFO non-empty.
  - noc_data_o = owner FIFO head (0 when idle).
  - A transfer occurs when noc_tx_o && noc_credit_i; it pops the owner FIFO.
  - Data is held stable while noc_credit_i = 0.
- State machine (IDLE, HEADER, SIZE, PAYLOAD):
  - IDLE: search sources starting at ptr+1, circular, for the first non-empty FIFO. Register owner and grant_o, go to HEADER. This is a 1-cycle arbitration bubble.
  - HEADER: on transfer -> SIZE.
  - SIZE: on transfer, load remaining = flit value (unsigned, full FLIT_SIZE width). If value = 0, the packet is complete -> IDLE; else -> PAYLOAD.
  - PAYLOAD: on transfer, remaining decrements. The transfer with remaining = 1 completes the packet -> IDLE.
  - On packet completion: ptr <= owner and grant_o <= 0.
- Ownership: the owner FIFO running empty mid-packet stalls the output (noc_tx_o = 0) and keeps ownership. No timeout.
- Latency: a flit pushed at edge E0 into an idle mux is granted at E1 and can transfer at E2. After that, one flit per cycle while credit is available.
- Back-to-back packets: there is always one IDLE cycle between packets, including consecutive packets from the same source.
- Reset mid-packet: asynchronous clear of everything. The in-flight packet is truncated and noc_tx_o drops immediately. Recovering the downstream router is the system's responsibility.

Optional Feature:
HERMES_INJ_MUX_STATS_EN:
- Defined: pkt_count_o exists. pkt_count_o[i] increments by 1 on the completion transfer of each packet from source i and wraps modulo 2^32. Reset value 0.
- Undefined: the port and its counters are absent, and behaviour is otherwise identical.

Test Plan:
1. N_SRC=2, src0 pushes 0x00000102, 2, 0xA, 0xB; noc_credit_i=1 -> noc_data_o 0x102, 2, 0xA, 0xB on 4 consecutive cycles from the 2nd cycle after the first push; grant_o=01 during the packet; busy_o falls after the last flit.
2. After reset, src0 and src1 each load a 1-payload packet in the same cycle -> src0 packet fully, 1 idle cycle, then src1 packet; no interleaving. A second round with both pending again -> src0 then src1 (pointer rotates).
3. src0 packet with size 6; noc_credit_i=0 for 10 cycles after the header -> noc_data_o holds the size flit, src0 FIFO reaches 4 and src_credit_o[0]=0; after credit returns, all 8 flits arrive in order with no loss.
4. Size-0 packet (header 0x0201, size 0) -> exactly 2 flits out, state returns to IDLE; the next queued packet is granted after 1 idle cycle.
5. Assert rst_i mid-PAYLOAD -> noc_tx_o, grant_o and busy_o go to 0 before the next edge, and src_credit_o goes to all 1; a new packet after reset release goes out intact.
6. With HERMES_INJ_MUX_STATS_EN: 3 packets from src1 and 1 from src0 -> pkt_count_o[1]=3, pkt_count_o[0]=1; preload 0xFFFFFFFF via force, one packet -> wraps to 0.
